// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI target receiver with oversampled inputs, valid/ready word output and MISO response
module spi_slave_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sck,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic [CNT_WIDTH-1:0]  byte_count,
    output logic                  overrun
);

    localparam logic SCK_IDLE    = (CPOL != 0);
    localparam logic SAMPLE_RISE = (CPOL == CPHA);
    localparam int   BW          = $clog2(DATA_WIDTH + 1);
    localparam logic [BW-1:0] FULL = BW'(DATA_WIDTH);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state, next_state;

    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, cs_sync;
    logic                   sck_hist;
    logic                   sck_s, mosi_s, cs_active;
    logic                   sample_edge, shift_edge;
    logic                   start, stop, word_done;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_WIDTH-1:0]  rx_shift, tx_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= {SYNC_STAGES{SCK_IDLE}};
            mosi_sync <= '0;
            cs_sync   <= '1;
            sck_hist  <= SCK_IDLE;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sck_hist  <= sck_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s       = sck_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign cs_active   = ~cs_sync[SYNC_STAGES-1];
    assign sample_edge = SAMPLE_RISE ? (sck_s & ~sck_hist) : (~sck_s & sck_hist);
    assign shift_edge  = SAMPLE_RISE ? (~sck_s & sck_hist) : (sck_s & ~sck_hist);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A completed word is delivered before a coincident CS release is acted on.
    always_comb begin
        next_state = state;
        start      = 1'b0;
        stop       = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (cs_active) begin
                    next_state = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (bit_cnt == FULL) begin
                    word_done = 1'b1;
                end else if (!cs_active) begin
                    next_state = IDLE;
                    stop       = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            byte_count  <= '0;
            overrun     <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
        end else begin
            frame_start <= start;
            frame_end   <= stop;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (start) begin
                byte_count  <= '0;
                bit_cnt     <= '0;
                overrun     <= 1'b0;
                spi_miso_oe <= 1'b1;
                spi_miso    <= tx_data[DATA_WIDTH-1];
                // CPHA=0 has already presented the MSB, so the first shift edge moves to the next bit.
                tx_shift    <= (CPHA == 0) ? (tx_data << 1) : tx_data;
            end else if (stop) begin
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
                bit_cnt     <= '0;
            end else if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
                byte_count <= byte_count + 1'b1;
                bit_cnt    <= '0;
                tx_shift   <= tx_data;
            end else if (state == ACTIVE) begin
                if (sample_edge) begin
                    rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
                    bit_cnt  <= bit_cnt + 1'b1;
                end
                if (shift_edge) begin
                    spi_miso <= tx_shift[DATA_WIDTH-1];
                    tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI target (slave) endpoint; the receiving end of the SPI link whose SCK the controller-side clock divider generates.
- Oversamples external spi_sck/spi_mosi/spi_cs_n in the system clock domain and deserialises MSB-first words.
- Hands each word to the LED-matrix frame logic over a valid/ready interface, and shifts a response word out on spi_miso.
- Reports frame boundaries, byte position and overrun.

Parameters:
DATA_WIDTH, 8, bits per SPI word.
SYNC_STAGES, 2, synchroniser flops on spi_sck, spi_mosi, spi_cs_n (min 2).
CPOL, 0, SCK idle level.
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge.
CNT_WIDTH, 16, width of byte_count.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  asynchronous, active-low reset.
spi_sck  in  1  external SPI clock, asynchronous to clk.
spi_mosi  in  1  external serial data in.
spi_cs_n  in  1  external chip select, active low.
spi_miso  out  1  serial response data.
spi_miso_oe  out  1  MISO drive enable, equals synchronised CS active.
tx_data  in  DATA_WIDTH  response word, captured at word start.
rx_data  out  DATA_WIDTH  received word, held while rx_valid.
rx_valid  out  1  received word available.
rx_ready  in  1  consumer accepts rx_data when rx_valid & rx_ready.
frame_start  out  1  1-cycle pulse on CS assertion.
frame_end  out  1  1-cycle pulse on CS deassertion.
byte_count  out  CNT_WIDTH  words completed in current frame.
overrun  out  1  sticky; set when a word is dropped.

Behaviour:
- Reset (rst_n low, async): all synchroniser/edge flops cleared, with the sck chain set to CPOL and the cs chain set to 1. Outputs: rx_data=0, rx_valid=0, frame_start=0, frame_end=0, byte_count=0, overrun=0, spi_miso=0, spi_miso_oe=0. Bit counter=0. State=IDLE.
- Synchronisation: each input passes through SYNC_STAGES flops plus one history flop. Edges are detected by comparing the last synchronised value to the history flop.
- Sample edge: rising if CPOL==CPHA, else falling. Shift edge is the opposite edge.
- Supported rate: SCK high and low phases each >= 4 clk. Faster SCK is unsupported.
- State IDLE: waits for synchronised CS low. On that transition, go to ACTIVE and drive the following:
  - frame_start=1 for one cycle;
  - byte_count=0, bit counter=0, overrun cleared;
  - tx shift register loaded from tx_data;
  - spi_miso_oe=1, spi_miso=tx_data MSB.
- State ACTIVE, on each sample edge: shift synchronised MOSI into the LSB of the rx shift register and increment the bit counter.
- Word completion: when the bit counter reaches DATA_WIDTH, the word is complete. In the next clk:
  - if rx_valid==0, or rx_valid and rx_ready in the same cycle: rx_data=word, rx_valid=1;
  - else: word dropped, overrun=1, rx_data unchanged;
  - in both cases: byte_count += 1 (wraps at 2^CNT_WIDTH), bit counter=0, tx shift register reloaded from tx_data.
- Latency: rx_valid rises at most SYNC_STAGES+2 clk after the physical final sample edge.
- rx_valid clears the cycle after rx_valid & rx_ready. rx_data is stable while rx_valid=1.
- MISO shifting:
  - on each shift edge in ACTIVE, spi_miso = next bit of the tx shift register, MSB first;
  - CPHA=1: the first shift edge presents the MSB;
  - CPHA=0: the MSB is already presented at CS assertion, and the shift edge following the final sample edge presents the reloaded word's MSB.
- CS deassertion (synchronised CS high) from ACTIVE:
  - frame_end=1 for one cycle, state=IDLE, spi_miso_oe=0, spi_miso=0;
  - partial word discarded, no rx_valid;
  - byte_count holds its value until the next frame_start;
  - a pending rx_valid is kept.
- Edges while in IDLE: ignored. SCK edges in the same synchronised cycle as the CS assertion are ignored.
- Simultaneous word completion and CS deassertion in the same clk: the word is delivered, then frame_end fires.
- overrun: sticky until the next frame_start or reset.

Test Plan:
1. Mode 0, SCK = clk/10, CS low, send 0xA5 then 0x3C, rx_ready=1 → rx_valid pulses twice with rx_data 0xA5, 0x3C; byte_count=2; frame_start then frame_end one pulse each; overrun=0.
2. tx_data=0xC3 at CS fall, second word tx_data=0x5A; capture MISO on the controller's sample edges → controller reads 0xC3 then 0x5A; spi_miso_oe=0 after CS high.
3. rx_ready=0, send 0x11, 0x22, 0x33 → rx_data stays 0x11 with rx_valid=1; overrun=1 after the second word; byte_count=3; next frame_start clears overrun.
4. CS high after 5 bits of 0xFF, then new frame sending 0x81 → no rx_valid for the partial word; second frame rx_data=0x81, byte_count=1.
5. Parameter runs CPOL/CPHA = (1,1), (0,1), (1,0), each sending 0x96 with a 0x69 response → rx_data=0x96 and MISO decodes 0x69 in every mode.
6. Assert rst_n=0 mid-word (after 3 bits), release, send 0x7E → all outputs at reset values during reset; the next full frame yields rx_data=0x7E, byte_count=1.
